// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor generator W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) from a quarter-wave cosine table,
// with a 2-stage registered pipeline, conjugate mode and a radix-2 DIF stage sequencer.
module fft_twiddle_gen #(
    parameter  int N_PT = 64,
    parameter  int TW_W = 10,
    parameter  int FRAC = 8,
    localparam int AW   = $clog2(N_PT),
    localparam int SW   = $clog2(AW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_valid,
    input  logic [AW-1:0]          i_addr,
    input  logic                   i_inv,
    input  logic                   i_start,
    input  logic [SW-1:0]          i_stage,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_valid,
    output logic [AW-1:0]          o_addr,
    output logic signed [TW_W-1:0] o_re,
    output logic signed [TW_W-1:0] o_im
);

    localparam int QN = N_PT / 4;
    localparam int RW = AW - 2;
    localparam int JW = AW - 1;
    localparam logic [JW-1:0] J_LAST = JW'(N_PT / 2 - 1);

    // round-half-away-from-zero of 2^FRAC*cos(2*pi*m/N_PT), integer Taylor series in Q28
    function automatic logic signed [TW_W-1:0] cos_q(input int m);
        longint s_one, x, x2, term, sum, v, d;
        s_one = longint'(1) << 28;
        x     = (longint'(2) * longint'(843314857) * longint'(m)) / longint'(N_PT);
        x2    = (x * x) / s_one;
        term  = s_one;
        sum   = s_one;
        for (int n = 1; n <= 14; n++) begin
            d    = longint'(2 * n) * longint'(2 * n - 1);
            term = -((term * x2) / s_one) / d;
            sum  = sum + term;
        end
        v = sum * (longint'(1) << FRAC);
        if (v >= 0) v = (v + s_one / 2) / s_one;
        else        v = -((-v + s_one / 2) / s_one);
        return TW_W'(v);
    endfunction

    logic signed [TW_W-1:0] w_tab [0:QN];

    for (genvar g = 0; g <= QN; g++) begin : g_tab
        localparam logic signed [TW_W-1:0] CV = cos_q(g);
        assign w_tab[g] = CV;
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state_nx;
    logic [SW-1:0] r_s, w_s_nx;
    logic [JW-1:0] r_j, w_j_nx, w_mask;
    logic          r_sinv, w_sinv_nx;
    logic          w_req_v, w_req_inv, w_req_last;
    logic [AW-1:0] w_req_k, w_seq_k;
    logic [RW:0]   w_ai, w_bi;

    logic [2:1]             r_vld_pipe, r_last_pipe;
    logic signed [TW_W-1:0] r_a, r_b, r_re, r_im, w_re, w_im;
    logic [1:0]             r_q;
    logic                   r_inv;
    logic [AW-1:0]          r_k, r_addr;

    // (j mod (N >> (s+1))) << s, the modulus being a power of two
    assign w_mask  = J_LAST >> r_s;
    assign w_seq_k = {1'b0, r_j & w_mask} << r_s;

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_j_nx     = r_j;
        w_sinv_nx  = r_sinv;
        w_req_v    = 1'b0;
        w_req_k    = i_addr;
        w_req_inv  = i_inv;
        w_req_last = 1'b0;
        case (r_state)
            IDLE: begin
                // a start, even an out-of-range one, swallows a same-cycle lookup
                if (i_start) begin
                    if (int'(i_stage) < AW) begin
                        w_state_nx = RUN;
                        w_s_nx     = i_stage;
                        w_j_nx     = '0;
                        w_sinv_nx  = i_inv;
                    end
                end else if (i_valid) begin
                    w_req_v = 1'b1;
                end
            end
            RUN: begin
                w_req_v    = 1'b1;
                w_req_k    = w_seq_k;
                w_req_inv  = r_sinv;
                w_req_last = (r_j == J_LAST);
                w_j_nx     = r_j + 1'b1;
                if (r_j == J_LAST) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_ai = {1'b0, w_req_k[RW-1:0]};
    assign w_bi = (RW+1)'(QN) - w_ai;

    always_comb begin
        w_re = r_a;
        w_im = -r_b;
        case (r_q)
            2'd1:    begin w_re = -r_b; w_im = -r_a; end
            2'd2:    begin w_re = -r_a; w_im =  r_b; end
            2'd3:    begin w_re =  r_b; w_im =  r_a; end
            default: ;
        endcase
        if (r_inv) w_im = -w_im;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_j         <= '0;
            r_sinv      <= 1'b0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_inv       <= 1'b0;
            r_k         <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_addr      <= '0;
        end else if (i_en) begin
            r_state     <= w_state_nx;
            r_s         <= w_s_nx;
            r_j         <= w_j_nx;
            r_sinv      <= w_sinv_nx;
            r_vld_pipe  <= {r_vld_pipe[1], w_req_v};
            r_last_pipe <= {r_last_pipe[1], w_req_last};
            r_a         <= w_tab[w_ai];
            r_b         <= w_tab[w_bi];
            r_q         <= w_req_k[AW-1:AW-2];
            r_inv       <= w_req_inv;
            r_k         <= w_req_k;
            r_re        <= w_re;
            r_im        <= w_im;
            r_addr      <= r_k;
        end
    end

    assign o_busy  = (r_state == RUN);
    assign o_valid = r_vld_pipe[2];
    assign o_done  = r_last_pipe[2];
    assign o_addr  = r_addr;
    assign o_re    = r_re;
    assign o_im    = r_im;

endmodule
